rand_share_ctrl: RTL and testbench

- Shares one XNOR-feedback LFSR among NUM_REQ requesters (e.g. dither, scrambler, test-pattern consumers).
- Sequences the generator through three phases: seed, warm-up, then per-grant refill.
- Refill makes every delivered word at least STRIDE shifts away from the previous word.
- Round-robin arbitration with a one-cycle grant pulse carrying the word.

---
 rtl/rand_pkg.sv | 98 +++++++++
 rtl/rr_pick.sv | 40 ++++
 rtl/rand_share_ctrl.sv | 165 ++++++++++++++++
 tb/tb_rand_share_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rand_pkg.sv
// rand_pkg: shared definitions for LFSR-based random word sharing.
//   taps(width)        maximal-length XNOR feedback mask, widths 4..64
//                      (bit t-1 set for tap t; shift-left LFSR)
//   rand_share_state_t sequencing phases of rand_share_ctrl
//   lfsr_lockup(v, w)  true when the low w bits of v are all ones
package rand_pkg;

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    IDLE   = 2'd1,
    REFILL = 2'd2
  } rand_share_state_t;

  function automatic logic [63:0] t2(input int a, input int b);
    return (64'd1 << (a - 1)) | (64'd1 << (b - 1));
  endfunction

  function automatic logic [63:0] t4(input int a, input int b, input int c, input int d);
    return t2(a, b) | t2(c, d);
  endfunction

  function automatic logic [63:0] taps(input int width);
    logic [63:0] m;
    m = '0;
    case (width)
      4:  m = t2(4, 3);
      5:  m = t2(5, 3);
      6:  m = t2(6, 5);
      7:  m = t2(7, 6);
      8:  m = t4(8, 6, 5, 4);
      9:  m = t2(9, 5);
      10: m = t2(10, 7);
      11: m = t2(11, 9);
      12: m = t4(12, 6, 4, 1);
      13: m = t4(13, 4, 3, 1);
      14: m = t4(14, 5, 3, 1);
      15: m = t2(15, 14);
      16: m = t4(16, 15, 13, 4);
      17: m = t2(17, 14);
      18: m = t2(18, 11);
      19: m = t4(19, 6, 2, 1);
      20: m = t2(20, 17);
      21: m = t2(21, 19);
      22: m = t2(22, 21);
      23: m = t2(23, 18);
      24: m = t4(24, 23, 22, 17);
      25: m = t2(25, 22);
      26: m = t4(26, 6, 2, 1);
      27: m = t4(27, 5, 2, 1);
      28: m = t2(28, 25);
      29: m = t2(29, 27);
      30: m = t4(30, 6, 4, 1);
      31: m = t2(31, 28);
      32: m = t4(32, 22, 2, 1);
      33: m = t2(33, 20);
      34: m = t4(34, 27, 2, 1);
      35: m = t2(35, 33);
      36: m = t2(36, 25);
      37: m = t4(37, 5, 4, 3) | t2(2, 1);
      38: m = t4(38, 6, 5, 1);
      39: m = t2(39, 35);
      40: m = t4(40, 38, 21, 19);
      41: m = t2(41, 38);
      42: m = t4(42, 41, 20, 19);
      43: m = t4(43, 42, 38, 37);
      44: m = t4(44, 43, 18, 17);
      45: m = t4(45, 44, 42, 41);
      46: m = t4(46, 45, 26, 25);
      47: m = t2(47, 42);
      48: m = t4(48, 47, 21, 20);
      49: m = t2(49, 40);
      50: m = t4(50, 49, 24, 23);
      51: m = t4(51, 50, 36, 35);
      52: m = t2(52, 49);
      53: m = t4(53, 52, 38, 37);
      54: m = t4(54, 53, 18, 17);
      55: m = t2(55, 31);
      56: m = t4(56, 55, 35, 34);
      57: m = t2(57, 50);
      58: m = t2(58, 39);
      59: m = t4(59, 58, 38, 37);
      60: m = t2(60, 59);
      61: m = t4(61, 60, 46, 45);
      62: m = t4(62, 61, 6, 5);
      63: m = t2(63, 62);
      64: m = t4(64, 63, 61, 60);
      default: m = '0;
    endcase
    return m;
  endfunction

  function automatic logic lfsr_lockup(input logic [63:0] v, input int width);
    logic [63:0] mask;
    mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (v & mask) == mask;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req    [N-1:0]      request vector
//   last   [IDX_W-1:0]  index of the previous winner
//   onehot [N-1:0]      winner, one-hot (zero when no request)
//   idx    [IDX_W-1:0]  winner index
//   any                 at least one request present
// Scan order is last+1, last+2, ... modulo N, so the previous winner has
// lowest priority.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int           cand;
  logic [N-1:0] shifted;

  always_comb begin
    onehot  = '0;
    idx     = '0;
    any     = 1'b0;
    cand    = 0;
    shifted = '0;
    for (int i = 1; i <= N; i++) begin
      cand    = (int'(last) + i) % N;
      shifted = req >> cand;
      if (!any && shifted[0]) begin
        any    = 1'b1;
        idx    = IDX_W'(cand);
        onehot = N'(1) << cand;
      end
    end
  end

endmodule

// File: rtl/rand_share_ctrl.sv
// rand_share_ctrl: one XNOR-feedback LFSR shared among NUM_REQ requesters.
// After seeding the LFSR is stepped WARMUP times, then each grant delivers
// the current state and the LFSR is stepped STRIDE times before the next
// word is offered. Round-robin arbitration, one-cycle registered grant.
//   clk          clock
//   reset_n      asynchronous active-low reset
//   req          [NUM_REQ-1:0] level requests, held until granted
//   gnt          [NUM_REQ-1:0] one-hot grant pulse
//   rand_out     [WIDTH-1:0]   delivered word, valid with gnt, held otherwise
//   word_ready   high while a word is available (IDLE)
// Optional (macro RAND_SHARE_CTRL_RESEED_EN):
//   reseed_valid reload LFSR from reseed_data and restart warm-up
//   reseed_data  [WIDTH-1:0] new seed; all-ones is replaced by SEED
//
// state  | meaning
// WARMUP | stepping LFSR after seed load, cnt counts remaining steps
// IDLE   | word available, waiting for a request
// REFILL | stepping LFSR STRIDE times after a grant
module rand_share_ctrl
  import rand_pkg::*;
#(
  parameter int               WIDTH   = 32,
  parameter int               NUM_REQ = 4,
  parameter int               STRIDE  = WIDTH,
  parameter int               WARMUP  = 64,
  parameter logic [WIDTH-1:0] SEED    = WIDTH'(1),
  parameter logic [WIDTH-1:0] TAPS    = WIDTH'(rand_pkg::taps(WIDTH))
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [WIDTH-1:0]   rand_out,
  output logic               word_ready
`ifdef RAND_SHARE_CTRL_RESEED_EN
  ,
  input  logic               reseed_valid,
  input  logic [WIDTH-1:0]   reseed_data
`endif
);

  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_MAX = (WARMUP > 2 * WIDTH) ? WARMUP : 2 * WIDTH;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  if (rand_pkg::lfsr_lockup(64'(SEED), WIDTH)) begin : g_bad_seed
    $error("rand_share_ctrl: SEED must not be the all-ones lockup state");
  end
  if (TAPS == '0) begin : g_bad_taps
    $error("rand_share_ctrl: TAPS must not be zero");
  end
  if (WIDTH < 4 || WIDTH > 64) begin : g_bad_width
    $error("rand_share_ctrl: WIDTH out of range 4..64");
  end
  if (NUM_REQ < 1 || NUM_REQ > 16) begin : g_bad_nreq
    $error("rand_share_ctrl: NUM_REQ out of range 1..16");
  end
  if (STRIDE < 1 || STRIDE > 2 * WIDTH) begin : g_bad_stride
    $error("rand_share_ctrl: STRIDE out of range 1..2*WIDTH");
  end
  if (WARMUP < 1) begin : g_bad_warmup
    $error("rand_share_ctrl: WARMUP must be at least 1");
  end

  rand_share_state_t  fsm_q, fsm_d;
  logic [WIDTH-1:0]   state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [WIDTH-1:0]   rand_out_q, rand_out_d;
  logic [IDX_W-1:0]   last_q, last_d;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [WIDTH-1:0]   lfsr_next;
  logic               reseed_hit;
  logic [WIDTH-1:0]   reseed_load;

`ifdef RAND_SHARE_CTRL_RESEED_EN
  assign reseed_hit  = reseed_valid;
  assign reseed_load = rand_pkg::lfsr_lockup(64'(reseed_data), WIDTH) ? SEED : reseed_data;
`else
  assign reseed_hit  = 1'b0;
  assign reseed_load = SEED;
`endif

  assign lfsr_next = {state_q[WIDTH-2:0], ~^(state_q & TAPS)};

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req    (req),
    .last   (last_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q      <= rand_pkg::WARMUP;
      state_q    <= SEED;
      cnt_q      <= CNT_W'(WARMUP - 1);
      gnt_q      <= '0;
      rand_out_q <= '0;
      last_q     <= IDX_W'(NUM_REQ - 1);
    end else begin
      fsm_q      <= fsm_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      rand_out_q <= rand_out_d;
      last_q     <= last_d;
    end
  end

  // Reseed overrides whatever the current phase would have decided.
  always_comb begin
    fsm_d = fsm_q;
    if (reseed_hit) begin
      fsm_d = rand_pkg::WARMUP;
    end else begin
      case (fsm_q)
        rand_pkg::WARMUP: if (cnt_q == '0) fsm_d = IDLE;
        IDLE:             if (pick_any)    fsm_d = REFILL;
        REFILL:           if (cnt_q == '0) fsm_d = IDLE;
        default:          fsm_d = rand_pkg::WARMUP;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gnt_d      = '0;
    rand_out_d = rand_out_q;
    last_d     = last_q;
    if (reseed_hit) begin
      state_d = reseed_load;
      cnt_d   = CNT_W'(WARMUP - 1);
    end else begin
      case (fsm_q)
        rand_pkg::WARMUP, REFILL: begin
          state_d = lfsr_next;
          if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        end
        IDLE: begin
          if (pick_any) begin
            gnt_d      = pick_onehot;
            rand_out_d = state_q;
            last_d     = pick_idx;
            cnt_d      = CNT_W'(STRIDE - 1);
          end
        end
        default: ;
      endcase
    end
  end

  assign word_ready = (fsm_q == IDLE);
  assign gnt        = gnt_q;
  assign rand_out   = rand_out_q;

endmodule

// File: tb/tb_rand_share_ctrl.sv
// tb_rand_share_ctrl: directed bench for rand_share_ctrl with a word-level
// reference model (shifts-remaining countdown + software LFSR) compared
// every cycle, plus hand-computed LFSR words. A second instance covers
// NUM_REQ=1 with STRIDE=1.
module tb_rand_share_ctrl;

  localparam int         W       = 8;
  localparam int         NR      = 4;
  localparam int         STR     = 8;
  localparam int         WU      = 16;
  localparam logic [7:0] SEED_TB = 8'h01;
  localparam logic [7:0] TAPS_TB = 8'h8E;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [7:0] rand_out;
  logic       word_ready;
  logic       req1;
  logic       gnt1;
  logic [7:0] rand1;
  logic       ready1;
`ifdef RAND_SHARE_CTRL_RESEED_EN
  logic       reseed_valid;
  logic [7:0] reseed_data;
  logic       reseed_off = 1'b0;
  logic [7:0] reseed_zero = 8'h00;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rand_share_ctrl #(
    .WIDTH(W), .NUM_REQ(NR), .STRIDE(STR), .WARMUP(WU), .SEED(SEED_TB), .TAPS(TAPS_TB)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .req(req), .gnt(gnt), .rand_out(rand_out),
    .word_ready(word_ready)
`ifdef RAND_SHARE_CTRL_RESEED_EN
    , .reseed_valid(reseed_valid), .reseed_data(reseed_data)
`endif
  );

  rand_share_ctrl #(
    .WIDTH(W), .NUM_REQ(1), .STRIDE(1), .WARMUP(WU), .SEED(SEED_TB), .TAPS(TAPS_TB)
  ) u_dut_s1 (
    .clk(clk), .reset_n(reset_n), .req(req1), .gnt(gnt1), .rand_out(rand1),
    .word_ready(ready1)
`ifdef RAND_SHARE_CTRL_RESEED_EN
    , .reseed_valid(reseed_off), .reseed_data(reseed_zero)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] m_step(input logic [7:0] s);
    int ones;
    ones = 0;
    for (int b = 0; b < 8; b++) if (TAPS_TB[b] && s[b]) ones++;
    return {s[6:0], (ones % 2 == 0)};
  endfunction

  function automatic int m_pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= NR; k++) if (r[(last + k) % NR]) return (last + k) % NR;
    return 0;
  endfunction

  logic [7:0] m_lfsr;
  int         m_shifts;
  int         m_last;
  logic [3:0] e_gnt;
  logic [7:0] e_rand;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_lfsr   <= SEED_TB;
      m_shifts <= WU;
      m_last   <= NR - 1;
      e_gnt    <= 4'b0000;
      e_rand   <= 8'h00;
    end
`ifdef RAND_SHARE_CTRL_RESEED_EN
    else if (reseed_valid) begin
      m_lfsr   <= (reseed_data == 8'hFF) ? SEED_TB : reseed_data;
      m_shifts <= WU;
      e_gnt    <= 4'b0000;
    end
`endif
    else if (m_shifts != 0) begin
      m_lfsr   <= m_step(m_lfsr);
      m_shifts <= m_shifts - 1;
      e_gnt    <= 4'b0000;
    end else if (req != 4'b0000) begin
      e_gnt    <= 4'(1 << m_pick(req, m_last));
      e_rand   <= m_lfsr;
      m_last   <= m_pick(req, m_last);
      m_shifts <= STR;
    end else begin
      e_gnt <= 4'b0000;
    end
  end

  always @(negedge clk) begin
    check("cyc_gnt", 64'(gnt), 64'(e_gnt));
    check("cyc_rand_out", 64'(rand_out), 64'(e_rand));
    check("cyc_word_ready", 64'(word_ready), 64'(m_shifts == 0));
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_gnt(input int budget, output int cyc, output logic [3:0] g,
                          output logic [7:0] w);
    cyc = 0;
    g   = 4'b0000;
    w   = 8'h00;
    while (cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (gnt != 4'b0000) begin
        g = gnt;
        w = rand_out;
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL gnt_timeout waited=%0d required=grant", cyc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  int         cyc;
  logic [3:0] g;
  logic [7:0] w;
  int         cnt;
  logic [3:0] rr_seq [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [7:0] boot_words [3] = '{8'h60, 8'hAA, 8'h3E};
  logic [7:0] s1_words [3]   = '{8'h60, 8'hC1, 8'h82};

  initial begin
    reset_n = 1'b0;
    req     = 4'b0000;
    req1    = 1'b0;
`ifdef RAND_SHARE_CTRL_RESEED_EN
    reseed_valid = 1'b0;
    reseed_data  = 8'h00;
`endif
    repeat (3) @(negedge clk);
    check("reset_gnt", 64'(gnt), 64'h0);
    check("reset_rand_out", 64'(rand_out), 64'h0);
    check("reset_word_ready", 64'(word_ready), 64'h0);
    reset_n = 1'b1;

    // warm-up: exactly 16 edges
    for (int i = 1; i <= WU; i++) begin
      @(negedge clk);
      if (i == WU - 1) check("warmup_not_ready_15", 64'(word_ready), 64'h0);
      if (i == WU)     check("warmup_ready_16", 64'(word_ready), 64'h1);
    end

    // all requesting: rotation and 9-cycle spacing
    req = 4'b1111;
    wait_gnt(4, cyc, g, w);
    check("first_latency", 64'(cyc), 64'd1);
    check("first_gnt", 64'(g), 64'b0001);
    check("first_word", 64'(w), 64'h60);
    for (int k = 0; k < 4; k++) begin
      wait_gnt(20, cyc, g, w);
      check("rr_spacing", 64'(cyc), 64'(STR + 1));
      check("rr_gnt", 64'(g), 64'(rr_seq[k]));
      if (k < 2) check("rr_word", 64'(w), 64'(boot_words[k + 1]));
    end

    // single requester, then requester 0 joins at the third grant
    req = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      wait_gnt(20, cyc, g, w);
      check("solo_gnt", 64'(g), 64'b0100);
    end
    req = 4'b0101;
    wait_gnt(20, cyc, g, w);
    check("join_gnt0", 64'(g), 64'b0001);
    req = 4'b0100;
    wait_gnt(20, cyc, g, w);
    check("join_gnt2", 64'(g), 64'b0100);

    // request raised and withdrawn during REFILL: no grant
    repeat (2) @(negedge clk);
    req = 4'b0010;
    repeat (2) @(negedge clk);
    req = 4'b0000;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (gnt != 4'b0000) cnt++;
    end
    check("withdraw_no_gnt", 64'(cnt), 64'd0);
    check("withdraw_ready", 64'(word_ready), 64'h1);

    // reset in the grant cycle, then cold-boot sequence again
    req = 4'b1111;
    wait_gnt(4, cyc, g, w);
    check("pre_reset_gnt", 64'(g), 64'b1000);
    #2 reset_n = 1'b0;
    #1;
    check("midreset_gnt", 64'(gnt), 64'h0);
    check("midreset_rand_out", 64'(rand_out), 64'h0);
    check("midreset_ready", 64'(word_ready), 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    wait_gnt(30, cyc, g, w);
    check("reboot_latency", 64'(cyc), 64'd17);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) wait_gnt(20, cyc, g, w);
      check("reboot_gnt", 64'(g), 64'(4'(1 << k)));
      check("reboot_word", 64'(w), 64'(boot_words[k]));
    end
    req = 4'b0000;

`ifdef RAND_SHARE_CTRL_RESEED_EN
    cnt = 0;
    while (!word_ready && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("reseed_pre_ready", 64'(word_ready), 64'h1);
    req          = 4'b0001;
    reseed_valid = 1'b1;
    reseed_data  = 8'hFF;
    @(negedge clk);
    check("reseed_no_gnt", 64'(gnt), 64'h0);
    check("reseed_not_ready", 64'(word_ready), 64'h0);
    reseed_valid = 1'b0;
    wait_gnt(30, cyc, g, w);
    check("reseed_latency", 64'(cyc), 64'd17);
    check("reseed_gnt", 64'(g), 64'b0001);
    check("reseed_word", 64'(w), 64'h60);
    req = 4'b0000;
`endif

    // NUM_REQ=1, STRIDE=1: a grant every second cycle
    check("s1_ready", 64'(ready1), 64'h1);
    req1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("s1_gnt", 64'(gnt1), 64'((k % 2) == 0));
      check("s1_ready_pat", 64'(ready1), 64'((k % 2) == 1));
      if ((k % 2) == 0) check("s1_word", 64'(rand1), 64'(s1_words[k / 2]));
    end
    req1 = 1'b0;

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
